// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register with valid/ready flow control,
// synchronous flush, bubble insertion and an optional one-entry skid buffer.
//
// Handshake: a transfer on either side happens on a rising edge where
// valid & ready are both high. valid never depends on ready. Once raised,
// out_valid stays high and out_data/out_ctrl stay stable until out_ready
// accepts the word (or a flush/reset kills it). When out_valid is low,
// out_ctrl always shows BUBBLE_CTRL, so a bubble can never write state
// downstream.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W      = 101,
  parameter int unsigned        CTRL_W      = 3,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter bit                 SKID        = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  // Next content for the main (output) register, chosen per SKID mode.
  logic              main_load;
  logic              main_valid_n;
  logic [DATA_W-1:0] main_data_n;
  logic [CTRL_W-1:0] main_ctrl_n;

  if (SKID == 1'b0) begin : g_direct
    // Single register: ready whenever the held word leaves or none is held.
    always_comb begin
      in_ready     = out_ready | ~out_valid;
      main_load    = in_ready;
      main_valid_n = in_valid;
      main_data_n  = in_data;
      main_ctrl_n  = in_ctrl;
    end
  end else begin : g_skid
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Main refills from skid first so order is kept; in_ready is a pure
    // register output, which breaks the combinational ready chain.
    always_comb begin
      in_ready     = ~skid_valid;
      main_load    = out_ready | ~out_valid;
      main_valid_n = skid_valid | in_valid;
      main_data_n  = skid_valid ? skid_data : in_data;
      main_ctrl_n  = skid_valid ? skid_ctrl : in_ctrl;
    end

    // Skid entry: fills when main is stuck, drains whenever main reloads.
    // An input can only arrive while skid is empty, so a reload of main
    // never has to capture a new word into skid in the same cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        skid_valid <= 1'b0;
        skid_data  <= '0;
        skid_ctrl  <= '0;
      end else if (flush) begin
        skid_valid <= 1'b0;
      end else if (main_load) begin
        skid_valid <= 1'b0;
      end else if (in_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_ctrl  <= in_ctrl;
      end
    end
  end

  // Main register: flush beats any load; a bubble keeps the old data bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= BUBBLE_CTRL;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= BUBBLE_CTRL;
    end else if (main_load) begin
      out_valid <= main_valid_n;
      out_ctrl  <= main_valid_n ? main_ctrl_n : BUBBLE_CTRL;
      if (main_valid_n) begin
        out_data <= main_data_n;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance driven by
// directed scenarios, then random valid/ready traffic against expected queues.
module tb_pipe_stage_reg;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;
  localparam int unsigned W  = DW + CW;
  localparam logic [CW-1:0] BUB = 3'b101;

  logic clk = 1'b0;
  logic reset;

  logic          fl0, iv0, ir0, ov0, or0;
  logic [DW-1:0] id0, od0;
  logic [CW-1:0] ic0, oc0;
  logic          fl1, iv1, ir1, ov1, or1;
  logic [DW-1:0] id1, od1;
  logic [CW-1:0] ic1, oc1;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(fl0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0), .in_ctrl(ic0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ctrl(oc0)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_ctrl(ic1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ctrl(oc1)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    fl0 = 0; iv0 = 0; or0 = 0; id0 = '0; ic0 = '0;
    fl1 = 0; iv1 = 0; or1 = 0; id1 = '0; ic1 = '0;
    step();
    reset = 1'b0;
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL reset_ov0: got %0b expected 0", ov0); end
    n_cmp++; if (oc0 !== BUB) begin n_err++; $display("FAIL reset_oc0: got %0b expected %0b", oc0, BUB); end
    n_cmp++; if (od0 !== '0) begin n_err++; $display("FAIL reset_od0: got %0h expected 0", od0); end
    n_cmp++; if (ir0 !== 1'b1) begin n_err++; $display("FAIL reset_ir0: got %0b expected 1", ir0); end
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_ov1: got %0b expected 0", ov1); end
    n_cmp++; if (oc1 !== BUB) begin n_err++; $display("FAIL reset_oc1: got %0b expected %0b", oc1, BUB); end
    n_cmp++; if (od1 !== '0) begin n_err++; $display("FAIL reset_od1: got %0h expected 0", od1); end
    n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL reset_ir1: got %0b expected 1", ir1); end
  endtask

  task automatic test_stream;
    or0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      iv0 = 1'b1; id0 = DW'(i); ic0 = 3'b010;
      step();
      n_cmp++; if (ov0 !== 1'b1) begin n_err++; $display("FAIL stream_ov_%0d: got %0b expected 1", i, ov0); end
      n_cmp++; if (od0 !== DW'(i)) begin n_err++; $display("FAIL stream_od_%0d: got %0h expected %0h", i, od0, i); end
      n_cmp++; if (oc0 !== 3'b010) begin n_err++; $display("FAIL stream_oc_%0d: got %0b expected 010", i, oc0); end
    end
    iv0 = 1'b0;
    step();
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL stream_bubble_ov: got %0b expected 0", ov0); end
    n_cmp++; if (oc0 !== BUB) begin n_err++; $display("FAIL stream_bubble_oc: got %0b expected %0b", oc0, BUB); end
    n_cmp++; if (od0 !== 16'h3) begin n_err++; $display("FAIL stream_bubble_od_hold: got %0h expected 3", od0); end
  endtask

  task automatic test_stall;
    or0 = 1'b1; iv0 = 1'b1; id0 = 16'hA; ic0 = 3'b001;
    step();
    n_cmp++; if (od0 !== 16'hA) begin n_err++; $display("FAIL stall_load: got %0h expected a", od0); end
    or0 = 1'b0; id0 = 16'hB; ic0 = 3'b011;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ir0 !== 1'b0) begin n_err++; $display("FAIL stall_ir_%0d: got %0b expected 0", i, ir0); end
      step();
      n_cmp++; if (od0 !== 16'hA || ov0 !== 1'b1 || oc0 !== 3'b001) begin
        n_err++; $display("FAIL stall_hold_%0d: got v=%0b d=%0h c=%0b expected v=1 d=a c=001", i, ov0, od0, oc0);
      end
    end
    or0 = 1'b1;
    #1;
    n_cmp++; if (ir0 !== 1'b1) begin n_err++; $display("FAIL stall_ir_release: got %0b expected 1", ir0); end
    step();
    n_cmp++; if (od0 !== 16'hB || oc0 !== 3'b011) begin n_err++; $display("FAIL stall_next: got d=%0h c=%0b expected d=b c=011", od0, oc0); end
    iv0 = 1'b0;
    step();
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %0b expected 0", ov0); end
  endtask

  task automatic test_skid;
    or1 = 1'b1; iv1 = 1'b1; id1 = 16'hA; ic1 = 3'b001;
    step();
    n_cmp++; if (od1 !== 16'hA || ov1 !== 1'b1) begin n_err++; $display("FAIL skid_main: got v=%0b d=%0h expected v=1 d=a", ov1, od1); end
    or1 = 1'b0; id1 = 16'hB;
    step();
    n_cmp++; if (ir1 !== 1'b0) begin n_err++; $display("FAIL skid_full_ir: got %0b expected 0", ir1); end
    n_cmp++; if (od1 !== 16'hA) begin n_err++; $display("FAIL skid_full_od: got %0h expected a", od1); end
    // C is offered while in_ready is low; it must wait, not be lost.
    or1 = 1'b1; id1 = 16'hC;
    step();
    n_cmp++; if (od1 !== 16'hB || ov1 !== 1'b1) begin n_err++; $display("FAIL skid_order_b: got v=%0b d=%0h expected v=1 d=b", ov1, od1); end
    n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL skid_drain_ir: got %0b expected 1", ir1); end
    step();
    n_cmp++; if (od1 !== 16'hC || ov1 !== 1'b1) begin n_err++; $display("FAIL skid_order_c: got v=%0b d=%0h expected v=1 d=c", ov1, od1); end
    iv1 = 1'b0;
    step();
    n_cmp++; if (ov1 !== 1'b0 || oc1 !== BUB) begin n_err++; $display("FAIL skid_no_dup: got v=%0b c=%0b expected v=0 c=%0b", ov1, oc1, BUB); end
  endtask

  task automatic test_flush;
    or1 = 1'b0; iv1 = 1'b1; id1 = 16'h11; ic1 = 3'b010;
    step();
    id1 = 16'h22;
    step();
    n_cmp++; if (ir1 !== 1'b0 || od1 !== 16'h11) begin n_err++; $display("FAIL flush_fill: got ir=%0b d=%0h expected ir=0 d=11", ir1, od1); end
    fl1 = 1'b1; id1 = 16'h33;
    step();
    fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    n_cmp++; if (ov1 !== 1'b0 || oc1 !== BUB || ir1 !== 1'b1) begin
      n_err++; $display("FAIL flush_skid: got v=%0b c=%0b ir=%0b expected v=0 c=%0b ir=1", ov1, oc1, ir1, BUB);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL flush_gone_%0d: got v=%0b d=%0h expected v=0", i, ov1, od1); end
    end
    // SKID=0: word accepted in the flush cycle is discarded.
    or0 = 1'b1; iv0 = 1'b1; id0 = 16'h44; ic0 = 3'b000; fl0 = 1'b1;
    #1;
    n_cmp++; if (ir0 !== 1'b1) begin n_err++; $display("FAIL flush0_ir: got %0b expected 1", ir0); end
    step();
    fl0 = 1'b0; iv0 = 1'b0;
    n_cmp++; if (ov0 !== 1'b0 || oc0 !== BUB) begin n_err++; $display("FAIL flush0_bubble: got v=%0b c=%0b expected v=0 c=%0b", ov0, oc0, BUB); end
  endtask

  // One random cycle on both instances, checked against the expected queues.
  task automatic rand_cycle(input bit drain);
    logic [W-1:0] exp_w;
    iv0 = drain ? 1'b0 : 1'($urandom_range(0, 1));
    or0 = drain ? 1'b1 : 1'($urandom_range(0, 1));
    fl0 = drain ? 1'b0 : ($urandom_range(0, 63) == 0);
    id0 = DW'($urandom_range(0, 65535)); ic0 = CW'($urandom_range(0, 7));
    iv1 = drain ? 1'b0 : 1'($urandom_range(0, 1));
    or1 = drain ? 1'b1 : 1'($urandom_range(0, 1));
    fl1 = drain ? 1'b0 : ($urandom_range(0, 63) == 0);
    id1 = DW'($urandom_range(0, 65535)); ic1 = CW'($urandom_range(0, 7));
    #1;
    if (!ov0) begin
      n_cmp++; if (oc0 !== BUB) begin n_err++; $display("FAIL rand0_bubble_ctrl: got %0b expected %0b", oc0, BUB); end
    end
    if (ov0 && or0) begin
      exp_w = (exp0_q.size() > 0) ? exp0_q.pop_front() : 'x;
      n_cmp++; if ({oc0, od0} !== exp_w) begin n_err++; $display("FAIL rand0_data: got %0h expected %0h", {oc0, od0}, exp_w); end
    end
    if (iv0 && ir0) exp0_q.push_back({ic0, id0});
    if (fl0) exp0_q.delete();
    if (!ov1) begin
      n_cmp++; if (oc1 !== BUB) begin n_err++; $display("FAIL rand1_bubble_ctrl: got %0b expected %0b", oc1, BUB); end
    end
    if (ov1 && or1) begin
      exp_w = (exp1_q.size() > 0) ? exp1_q.pop_front() : 'x;
      n_cmp++; if ({oc1, od1} !== exp_w) begin n_err++; $display("FAIL rand1_data: got %0h expected %0h", {oc1, od1}, exp_w); end
    end
    if (iv1 && ir1) exp1_q.push_back({ic1, id1});
    if (fl1) exp1_q.delete();
    n_cmp++; if (exp0_q.size() > 1 || exp1_q.size() > 2) begin
      n_err++; $display("FAIL rand_occupancy: got %0d/%0d expected <=1/<=2", exp0_q.size(), exp1_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    exp0_q.delete();
    exp1_q.delete();
    for (int i = 0; i < 10000; i++) rand_cycle(1'b0);
    for (int i = 0; i < 4; i++) rand_cycle(1'b1);
    n_cmp++; if (exp0_q.size() != 0) begin n_err++; $display("FAIL rand0_lost: got %0d left expected 0", exp0_q.size()); end
    n_cmp++; if (exp1_q.size() != 0) begin n_err++; $display("FAIL rand1_lost: got %0d left expected 0", exp1_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_skid();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
